// File: rtl/fetch_redirect.sv
// fetch_redirect: fetch PC and IF/ID register with a BOOT/RUN/REDIR squash FSM; `BR_MISALIGN_EN adds misaligned-target trapping.
// Latency: an imem word reaches IF/ID one cycle after its address leaves pc_f; a taken branch costs 2 bubbles.
// Backpressure: stall_f freezes PC and IF/ID in RUN only; a taken branch overrides it, BOOT/REDIR ignore it.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall_f,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] inst_d,
  output logic        valid_d,
  output logic        flush_e,
  output logic        redirect_busy
`ifdef BR_MISALIGN_EN
  ,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_f_nxt, pc_q_nxt, pc_d_nxt, inst_d_nxt;
  logic        valid_d_nxt;
  logic [31:0] pc_inc;
  logic        misaligned;

  assign pc_inc = pc_f + 32'd4;

`ifdef BR_MISALIGN_EN
  assign misaligned = (br_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    pc_f_nxt      = pc_f;
    pc_q_nxt      = pc_q;
    pc_d_nxt      = pc_d;
    inst_d_nxt    = inst_d;
    valid_d_nxt   = valid_d;
    flush_e       = 1'b0;
    redirect_busy = 1'b0;
    case (state)
      BOOT: begin
        inst_d_nxt  = NOP_INST;
        valid_d_nxt = 1'b0;
        pc_q_nxt    = pc_f;
        pc_f_nxt    = pc_inc;
        state_nxt   = RUN;
      end
      RUN: begin
        if (br_taken) begin
          flush_e     = 1'b1;
          inst_d_nxt  = NOP_INST;
          valid_d_nxt = 1'b0;
          // A trapped (misaligned) target leaves the fetch stream where it is.
          if (!misaligned) begin
            pc_f_nxt  = br_target;
            state_nxt = REDIR;
          end
        end else if (!stall_f) begin
          pc_d_nxt    = pc_q;
          inst_d_nxt  = imem_rdata;
          valid_d_nxt = 1'b1;
          pc_q_nxt    = pc_f;
          pc_f_nxt    = pc_inc;
        end
      end
      REDIR: begin
        // imem_rdata here is the wrong-path word fetched in the branch cycle.
        redirect_busy = 1'b1;
        inst_d_nxt    = NOP_INST;
        valid_d_nxt   = 1'b0;
        pc_q_nxt      = pc_f;
        pc_f_nxt      = pc_inc;
        state_nxt     = RUN;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_f    <= RESET_PC;
      pc_q    <= RESET_PC;
      pc_d    <= RESET_PC;
      inst_d  <= NOP_INST;
      valid_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_f    <= pc_f_nxt;
      pc_q    <= pc_q_nxt;
      pc_d    <= pc_d_nxt;
      inst_d  <= inst_d_nxt;
      valid_d <= valid_d_nxt;
    end
  end

`ifdef BR_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= 32'd0;
    end else begin
      misalign_exc <= (state == RUN) && br_taken && misaligned;
      if ((state == RUN) && br_taken && misaligned) begin
        misalign_addr <= br_target;
      end
    end
  end
`endif

  // EX holds a bubble while redirecting, so a taken branch cannot legally arrive.
  assert property (@(posedge clk) disable iff (rst) !((state == REDIR) && br_taken));

endmodule
